// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// between NREQ write-domain requesters, with bounded bursts per grant.
// Optional feature: define FIFO_WR_ARB_STALL_CNT_EN to add the 16-bit
// saturating full-stall counter and its stall_cnt port.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST      = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]              req_last,
  input  logic                         wfull,
  output logic [NREQ-1:0]              ack,
  output logic [NREQ-1:0]              grant,
  output logic                         winc,
  output logic [DATA_WIDTH-1:0]        wdata,
  output logic                         busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   hi_idx;
  logic [PTR_W-1:0]   lo_idx;
  logic               hit_hi;
  logic               req_g;
  logic               last_g;

  // Index of the currently granted requester, decoded from the one-hot grant.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hit_hi = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = PTR_W'(i);
      if (req[i] && (i >= int'(rr_ptr))) begin
        hi_idx = PTR_W'(i);
        hit_hi = 1'b1;
      end
    end
    sel_idx = hit_hi ? hi_idx : lo_idx;
  end

  assign next_ptr = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  assign req_g    = |(req & grant);
  assign last_g   = |(req_last & grant);

  // Write port: grant is zero outside GRANT, so these collapse to 0 in IDLE/reset.
  assign winc = req_g & ~wfull;
  assign ack  = winc ? grant : '0;
  assign busy = (state == GRANT);

  // Steer the granted requester's word onto the FIFO data bus.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i] && winc) wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration FSM: grant, burst counting and release with pointer advance.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= NREQ'(1) << sel_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (winc) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
            if (last_g || (burst_cnt == CNT_W'(BURST - 1))) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end else if (!wfull && !req_g) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  // Saturating count of cycles where the granted requester is blocked by full.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if ((state == GRANT) && req_g && wfull && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NREQ=2, DATA_WIDTH=8, BURST=4).
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned BURST = 4;

  logic                 wclk;
  logic                 wrst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic                 wfull;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      grant;
  logic                 winc;
  logic [DW-1:0]        wdata;
  logic                 busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]          stall_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BURST(BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .wfull    (wfull),
    .ack      (ack),
    .grant    (grant),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold reset for two edges, release just after a rising edge.
  task automatic apply_reset();
    wrst_n   = 1'b0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    wfull    = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance past next edge.
  task automatic cyc(input string tag, input logic [1:0] r, input logic [7:0] d0,
                     input logic [7:0] d1, input logic [1:0] l, input logic f,
                     input logic ew, input logic [7:0] ed, input logic [1:0] eg,
                     input logic eb);
    req      = r;
    req_data = {d1, d0};
    req_last = l;
    wfull    = f;
    @(negedge wclk);
    check({tag, " winc"},  32'(winc),  32'(ew));
    check({tag, " wdata"}, 32'(wdata), 32'(ed));
    check({tag, " grant"}, 32'(grant), 32'(eg));
    check({tag, " ack"},   32'(ack),   ew ? 32'(eg) : 32'd0);
    check({tag, " busy"},  32'(busy),  32'(eb));
    @(posedge wclk);
    #1;
  endtask

  logic [7:0] i0, i1;
  logic [1:0] eg;
  logic [7:0] ed;

  initial begin
    // Reset state
    apply_reset();
    check("reset grant", 32'(grant), 32'd0);
    check("reset busy",  32'(busy),  32'd0);
    check("reset winc",  32'(winc),  32'd0);
    check("reset rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Single requester: 6 words, burst of 4 then re-grant for words 5-6
    cyc("t1 c0", 2'b01, 8'h11, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("t1 c%0d", k + 1), 2'b01, 8'(8'h11 + k), 8'h00, 2'b00, 1'b0,
          1'b1, 8'(8'h11 + k), 2'b01, 1'b1);
    end
    cyc("t1 c5", 2'b01, 8'h15, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t1 c6", 2'b01, 8'h15, 8'h00, 2'b00, 1'b0, 1'b1, 8'h15, 2'b01, 1'b1);
    cyc("t1 c7", 2'b01, 8'h16, 8'h00, 2'b01, 1'b0, 1'b1, 8'h16, 2'b01, 1'b1);
    cyc("t1 c8", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);

    // Two requesters, continuous: grants alternate 0,1,0,1 with one idle cycle
    apply_reset();
    i0 = 8'hA0;
    i1 = 8'hB0;
    for (int r = 0; r < 4; r++) begin
      eg = 2'b01 << (r % 2);
      cyc($sformatf("t2 r%0d idle", r), 2'b11, i0, i1, 2'b00, 1'b0,
          1'b0, 8'h00, 2'b00, 1'b0);
      for (int k = 0; k < 4; k++) begin
        ed = (r % 2 == 1) ? i1 : i0;
        cyc($sformatf("t2 r%0d w%0d", r, k), 2'b11, i0, i1, 2'b00, 1'b0,
            1'b1, ed, eg, 1'b1);
        if (r % 2 == 1) i1 = i1 + 8'd1;
        else            i0 = i0 + 8'd1;
      end
      check($sformatf("t2 r%0d rr_ptr", r), 32'(dut.rr_ptr), 32'((r + 1) % 2));
    end

    // Full stall: 3 cycles of wfull after the 2nd word
    apply_reset();
    cyc("t3 c0", 2'b01, 8'h31, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t3 c1", 2'b01, 8'h31, 8'h00, 2'b00, 1'b0, 1'b1, 8'h31, 2'b01, 1'b1);
    cyc("t3 c2", 2'b01, 8'h32, 8'h00, 2'b00, 1'b0, 1'b1, 8'h32, 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("t3 stall%0d", k), 2'b01, 8'h33, 8'h00, 2'b00, 1'b1,
          1'b0, 8'h00, 2'b01, 1'b1);
    end
    cyc("t3 c6", 2'b01, 8'h33, 8'h00, 2'b00, 1'b0, 1'b1, 8'h33, 2'b01, 1'b1);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("t3 stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    cyc("t3 c7", 2'b01, 8'h34, 8'h00, 2'b00, 1'b0, 1'b1, 8'h34, 2'b01, 1'b1);
    cyc("t3 c8", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);

    // Early last on requester 1, requester 0 waiting is served next
    apply_reset();
    cyc("t4 c0", 2'b10, 8'h00, 8'h71, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t4 c1", 2'b11, 8'h41, 8'h71, 2'b10, 1'b0, 1'b1, 8'h71, 2'b10, 1'b1);
    check("t4 rr_ptr", 32'(dut.rr_ptr), 32'd0);
    cyc("t4 c2", 2'b11, 8'h41, 8'h72, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t4 c3", 2'b11, 8'h41, 8'h72, 2'b11, 1'b0, 1'b1, 8'h41, 2'b01, 1'b1);
    cyc("t4 c4", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);

    // Withdrawal after one word
    apply_reset();
    cyc("t5 c0", 2'b01, 8'h51, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t5 c1", 2'b01, 8'h51, 8'h00, 2'b00, 1'b0, 1'b1, 8'h51, 2'b01, 1'b1);
    cyc("t5 c2", 2'b00, 8'h52, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1);
    cyc("t5 c3", 2'b00, 8'h52, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    check("t5 rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // Reset mid-burst with rr_ptr=1; arbitration restarts from requester 0
    apply_reset();
    cyc("t6 c0", 2'b01, 8'h61, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t6 c1", 2'b01, 8'h61, 8'h00, 2'b01, 1'b0, 1'b1, 8'h61, 2'b01, 1'b1);
    cyc("t6 c2", 2'b01, 8'h62, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t6 c3", 2'b01, 8'h62, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1);
    cyc("t6 c4", 2'b01, 8'h62, 8'h00, 2'b00, 1'b0, 1'b1, 8'h62, 2'b01, 1'b1);
    check("t6 rr_ptr pre", 32'(dut.rr_ptr), 32'd1);
    req      = 2'b11;
    req_data = {8'h81, 8'h63};
    @(negedge wclk);
    check("t6 word2 winc", 32'(winc), 32'd1);
    #2;
    wrst_n = 1'b0;
    #1;
    check("t6 rst winc",  32'(winc),  32'd0);
    check("t6 rst ack",   32'(ack),   32'd0);
    check("t6 rst grant", 32'(grant), 32'd0);
    check("t6 rst busy",  32'(busy),  32'd0);
    check("t6 rst wdata", 32'(wdata), 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("t6 rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    cyc("t6 c6", 2'b11, 8'h63, 8'h81, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    cyc("t6 c7", 2'b11, 8'h63, 8'h81, 2'b00, 1'b0, 1'b1, 8'h63, 2'b01, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
